pc_unit: RTL and testbench

// Parametrised program-counter unit for the processor datapath. It extends the

---
 rtl/pc_if.sv | 27 ++
 rtl/pc_unit.sv | 93 +++++++++
 tb/tb_pc_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pc_if.sv
`timescale 1ns/1ps
// pc_if: control-side handshake and status bundle of the program-counter unit
interface pc_if #(
  parameter int ADDR_W = 18,
  parameter int OFF_W = 10,
  parameter int SP_W = 4
);
  logic stall;
  logic [2:0] op;
  logic [ADDR_W-1:0] target;
  logic [OFF_W-1:0] offset;
  logic rd_en;
  logic [ADDR_W-1:0] pc_out;
  logic [SP_W-1:0] sp_count;
  logic stk_full;
  logic stk_empty;
  logic fault_ovf;
  logic fault_unf;
  modport master (
    output stall, op, target, offset, rd_en,
    input pc_out, sp_count, stk_full, stk_empty, fault_ovf, fault_unf
  );
  modport slave (
    input stall, op, target, offset, rd_en,
    output pc_out, sp_count, stk_full, stk_empty, fault_ovf, fault_unf
  );
endinterface

// File: rtl/pc_unit.sv
`timescale 1ns/1ps
// pc_unit: program counter with relative branch, return-address stack, stall and sticky stack faults
module pc_unit #(
  parameter int ADDR_W = 18,
  parameter int OFF_W = 10,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(3),
  parameter int INC_STEP = 1,
  parameter int STACK_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus,
  output wire [ADDR_W-1:0] pc_bus
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_INC = 3'b001,
    OP_JUMP = 3'b010,
    OP_BRANCH = 3'b011,
    OP_CALL = 3'b100,
    OP_RET = 3'b101
  } op_e;
  logic [ADDR_W-1:0] r_pc;
  logic [SP_W-1:0] r_sp;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic r_ovf;
  logic r_unf;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [SP_W-1:0] w_sp_nxt;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_ovf_nxt;
  logic w_unf_nxt;
  assign w_full = r_sp == SP_W'(STACK_DEPTH);
  assign w_empty = r_sp == '0;
  assign w_inc = r_pc + ADDR_W'(INC_STEP);
  // A full stack truncates sp to 0 here, so the top-of-stack index still wraps to the last entry
  assign w_wr_idx = r_sp[IDX_W-1:0];
  assign w_rd_idx = w_wr_idx - IDX_W'(1);
  always_comb begin
    w_pc_nxt = r_pc;
    w_sp_nxt = r_sp;
    w_push = 1'b0;
    w_ovf_nxt = r_ovf;
    w_unf_nxt = r_unf;
    case (bus.op)
      OP_INC: w_pc_nxt = w_inc;
      OP_JUMP: w_pc_nxt = bus.target;
      OP_BRANCH: w_pc_nxt = r_pc + ADDR_W'($signed(bus.offset));
      OP_CALL:
        if (w_full) w_ovf_nxt = 1'b1;
        else begin
          w_push = 1'b1;
          w_sp_nxt = r_sp + SP_W'(1);
          w_pc_nxt = bus.target;
        end
      OP_RET:
        if (w_empty) w_unf_nxt = 1'b1;
        else begin
          w_pc_nxt = r_stack[w_rd_idx];
          w_sp_nxt = r_sp - SP_W'(1);
        end
      default: w_pc_nxt = r_pc;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_VEC;
      r_sp <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!bus.stall) begin
      r_pc <= w_pc_nxt;
      r_sp <= w_sp_nxt;
      r_ovf <= w_ovf_nxt;
      r_unf <= w_unf_nxt;
      if (w_push) r_stack[w_wr_idx] <= w_inc;
    end
  end
  assign bus.pc_out = r_pc;
  assign bus.sp_count = r_sp;
  assign bus.stk_full = w_full;
  assign bus.stk_empty = w_empty;
  assign bus.fault_ovf = r_ovf;
  assign bus.fault_unf = r_unf;
  assign pc_bus = bus.rd_en ? r_pc : {ADDR_W{1'bz}};
endmodule

// File: tb/tb_pc_unit.sv
`timescale 1ns/1ps
// tb_pc_unit: directed checks of reset, increment, branch wrap, call/return stack, faults, stall and bus gating
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst;
  wire [17:0] pc_bus;
  int checks = 0;
  int failures = 0;
  pc_if #(.ADDR_W(18), .OFF_W(10), .SP_W(4)) bus ();
  pc_unit #(
    .ADDR_W(18), .OFF_W(10), .RESET_VEC(18'd3), .INC_STEP(1), .STACK_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .pc_bus(pc_bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op_step(input logic [2:0] op, input logic [17:0] tgt, input logic [9:0] off);
    bus.op = op;
    bus.target = tgt;
    bus.offset = off;
    tick();
  endtask
  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.op = 3'b000;
    bus.target = '0;
    bus.offset = '0;
    bus.rd_en = 1'b0;
    tick();
    tick();
    chk("reset_pc", 32'(bus.pc_out), 32'h3);
    chk("reset_sp", 32'(bus.sp_count), 32'h0);
    chk("reset_empty", 32'(bus.stk_empty), 32'h1);
    chk("reset_full", 32'(bus.stk_full), 32'h0);
    chk("reset_ovf", 32'(bus.fault_ovf), 32'h0);
    chk("reset_unf", 32'(bus.fault_unf), 32'h0);
    rst = 1'b0;
    op_step(3'b001, '0, '0);
    chk("inc1", 32'(bus.pc_out), 32'h4);
    op_step(3'b001, '0, '0);
    chk("inc2", 32'(bus.pc_out), 32'h5);
    op_step(3'b001, '0, '0);
    chk("inc3", 32'(bus.pc_out), 32'h6);
    chk("inc_sp", 32'(bus.sp_count), 32'h0);
    op_step(3'b000, 18'h2AAAA, '0);
    chk("hold", 32'(bus.pc_out), 32'h6);
    op_step(3'b110, 18'h2AAAA, '0);
    chk("reserved6", 32'(bus.pc_out), 32'h6);
    op_step(3'b111, 18'h2AAAA, 10'h001);
    chk("reserved7", 32'(bus.pc_out), 32'h6);
    op_step(3'b010, 18'h00010, '0);
    chk("jump", 32'(bus.pc_out), 32'h10);
    op_step(3'b011, '0, 10'h3FC);
    chk("branch_neg", 32'(bus.pc_out), 32'hC);
    op_step(3'b010, 18'h3FFFF, '0);
    op_step(3'b001, '0, '0);
    chk("inc_wrap", 32'(bus.pc_out), 32'h0);
    op_step(3'b011, '0, 10'h1FF);
    chk("branch_pos", 32'(bus.pc_out), 32'h1FF);
    op_step(3'b011, '0, 10'h200);
    chk("branch_wrap", 32'(bus.pc_out), 32'h3FFFF);
    op_step(3'b010, 18'h00020, '0);
    op_step(3'b100, 18'h00100, '0);
    chk("call_pc", 32'(bus.pc_out), 32'h100);
    chk("call_sp", 32'(bus.sp_count), 32'h1);
    chk("call_empty", 32'(bus.stk_empty), 32'h0);
    op_step(3'b101, '0, '0);
    chk("ret_pc", 32'(bus.pc_out), 32'h21);
    chk("ret_sp", 32'(bus.sp_count), 32'h0);
    chk("ret_empty", 32'(bus.stk_empty), 32'h1);
    op_step(3'b010, 18'h01000, '0);
    for (int i = 0; i < 8; i++) begin
      op_step(3'b100, 18'(32'h1000 + (i + 1) * 32'h100), '0);
      chk($sformatf("nest_call_pc%0d", i), 32'(bus.pc_out), 32'h1000 + (i + 1) * 32'h100);
      chk($sformatf("nest_call_sp%0d", i), 32'(bus.sp_count), 32'(i + 1));
    end
    chk("stk_full", 32'(bus.stk_full), 32'h1);
    chk("no_ovf_yet", 32'(bus.fault_ovf), 32'h0);
    op_step(3'b100, 18'h2AAAA, '0);
    chk("ovf_pc_hold", 32'(bus.pc_out), 32'h1800);
    chk("ovf_sp_hold", 32'(bus.sp_count), 32'h8);
    chk("ovf_flag", 32'(bus.fault_ovf), 32'h1);
    for (int i = 7; i >= 0; i--) begin
      op_step(3'b101, '0, '0);
      chk($sformatf("lifo_pc%0d", i), 32'(bus.pc_out), 32'h1001 + i * 32'h100);
      chk($sformatf("lifo_sp%0d", i), 32'(bus.sp_count), 32'(i));
    end
    chk("no_unf_yet", 32'(bus.fault_unf), 32'h0);
    op_step(3'b101, '0, '0);
    chk("unf_pc_hold", 32'(bus.pc_out), 32'h1001);
    chk("unf_flag", 32'(bus.fault_unf), 32'h1);
    chk("ovf_sticky", 32'(bus.fault_ovf), 32'h1);
    op_step(3'b001, '0, '0);
    chk("op_after_fault", 32'(bus.pc_out), 32'h1002);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op_step(3'b010, 18'h12345, '0);
      chk($sformatf("stall_pc%0d", i), 32'(bus.pc_out), 32'h1002);
    end
    op_step(3'b100, 18'h00777, '0);
    chk("stall_call_sp", 32'(bus.sp_count), 32'h0);
    chk("stall_call_pc", 32'(bus.pc_out), 32'h1002);
    bus.stall = 1'b0;
    op_step(3'b010, 18'h12345, '0);
    chk("unstall_jump", 32'(bus.pc_out), 32'h12345);
    rst = 1'b1;
    bus.stall = 1'b1;
    op_step(3'b100, 18'h00555, '0);
    chk("rst_call_pc", 32'(bus.pc_out), 32'h3);
    chk("rst_call_sp", 32'(bus.sp_count), 32'h0);
    chk("rst_call_ovf", 32'(bus.fault_ovf), 32'h0);
    chk("rst_call_unf", 32'(bus.fault_unf), 32'h0);
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.op = 3'b000;
    bus.rd_en = 1'b0;
    #1;
    checks++;
    assert (pc_bus !== bus.pc_out)
    else begin
      failures++;
      $error("FAIL bus_hiz observed=%0h expected=z", pc_bus);
    end
    bus.rd_en = 1'b1;
    #1;
    chk("bus_drive", 32'(pc_bus), 32'h3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
